// File: rtl/module_stereo_sample_pacer_pkg.sv
// Shared audio constants and stereo sample types for the sample pacer and its FIFO.
package module_stereo_sample_pacer_pkg;

  localparam int SAMPLE_WIDTH       = 18;
  localparam int SAMPLE_PERIOD_CLKS = 2080;
  localparam int FIFO_DEPTH_DEF     = 4;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  localparam int STEREO_W = $bits(stereo_t);

endpackage

// File: rtl/module_stereo_sample_pacer_fifo.sv
// module_sample_fifo: synchronous stereo-word FIFO with push/pop, full/empty and occupancy level.
module module_sample_fifo
  import module_stereo_sample_pacer_pkg::*;
#(
  parameter int WIDTH = STEREO_W,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/module_stereo_sample_pacer.sv
// Stereo sample pacer: buffers bursty samples and releases one every SAMPLE_PERIOD clocks.
// Define SAMPLE_PACER_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of silence.
module module_stereo_sample_pacer
  import module_stereo_sample_pacer_pkg::*;
#(
  parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_CLKS,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] s_l,
  input  logic signed [SAMPLE_WIDTH-1:0] s_r,
  output logic                        sample_out_rdy,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out_l,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out_r,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_strobe;
  logic             r_underrun;
  sample_t          r_out_l;
  sample_t          r_out_r;
  logic             w_tick;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  stereo_t          w_head;
  stereo_t          w_tail;

  // Readiness looks only at the registered level, so a tick pop frees its slot one cycle later.
  assign w_tick  = (r_cnt == CNT_LAST);
  assign s_ready = reset && !w_full;
  assign w_push  = s_valid && s_ready;
  assign w_pop   = w_tick && !w_empty;
  assign w_tail  = '{l: s_l, r: s_r};

  module_sample_fifo #(
    .WIDTH(STEREO_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(w_tail),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      r_out_l    <= '0;
      r_out_r    <= '0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      r_strobe   <= w_tick;
      r_underrun <= w_tick && w_empty;
      if (w_pop) begin
        r_out_l <= w_head.l;
        r_out_r <= w_head.r;
      end
`ifndef SAMPLE_PACER_UNDERRUN_HOLD_EN
      else if (w_tick) begin
        r_out_l <= '0;
        r_out_r <= '0;
      end
`endif
    end
  end

  assign sample_out_rdy = r_strobe;
  assign underrun       = r_underrun;
  assign sample_out_l   = r_out_l;
  assign sample_out_r   = r_out_r;

endmodule

// File: tb/tb_module_stereo_sample_pacer.sv
// Bench for module_stereo_sample_pacer: directed scenarios plus randomized traffic against a queue model.
module tb_module_stereo_sample_pacer;

  localparam int SP    = 2080;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [17:0] s_l;
  logic signed [17:0] s_r;
  logic               sample_out_rdy;
  logic signed [17:0] sample_out_l;
  logic signed [17:0] sample_out_r;
  logic               underrun;
  logic [2:0]         fifo_level;

  module_stereo_sample_pacer #(.SAMPLE_PERIOD(SP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_l(s_l), .s_r(s_r), .sample_out_rdy(sample_out_rdy),
    .sample_out_l(sample_out_l), .sample_out_r(sample_out_r),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_strobe = 0;

`ifdef SAMPLE_PACER_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Reference model: a sample queue drained once per period, counted from reset release.
  logic [35:0]        m_q[$];
  int                 m_edges;
  int                 m_had;
  logic               m_strobe;
  logic               m_und;
  logic signed [17:0] m_l;
  logic signed [17:0] m_r;
  logic [35:0]        m_word;

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_edges  = 0;
      m_strobe = 1'b0;
      m_und    = 1'b0;
      m_l      = '0;
      m_r      = '0;
    end else begin
      m_had    = m_q.size();
      m_strobe = ((m_edges % SP) == SP - 1);
      m_und    = m_strobe && (m_had == 0);
      if (m_strobe && m_had > 0) begin
        m_word = m_q.pop_front();
        m_l    = m_word[35:18];
        m_r    = m_word[17:0];
      end else if (m_strobe && !HOLD) begin
        m_l = '0;
        m_r = '0;
      end
      if (s_valid && m_had < DEPTH) m_q.push_back({s_l, s_r});
      m_edges++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_strobe(output int at, output bit ok);
    ok = 1'b0;
    at = cyc;
    for (int i = 0; i < SP + 100; i++) begin
      step();
      if (sample_out_rdy === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int at;
    bit ok;
    reset = 1'b0; s_valid = 1'b0; s_l = '0; s_r = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({sample_out_rdy, underrun, sample_out_l, sample_out_r, fifo_level, s_ready} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: rdy=%b und=%b l=%0d r=%0d lvl=%0d s_ready=%b required all 0",
                 sample_out_rdy, underrun, sample_out_l, sample_out_r, fifo_level, s_ready);
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: s_ready=%b lvl=%0d required 1/0", s_ready, fifo_level);
    end
    last_strobe = cyc;
    wait_strobe(at, ok);
    n_cmp++;
    if (!ok || at - last_strobe !== SP) begin
      n_fail++;
      $display("FAIL first_strobe: ok=%0b after %0d cycles required %0d", ok, at - last_strobe, SP);
    end
    n_cmp++;
    if (underrun !== 1'b1 || sample_out_l !== 18'sd0 || sample_out_r !== 18'sd0) begin
      n_fail++;
      $display("FAIL first_strobe_data: und=%b l=%0d r=%0d required 1/0/0", underrun, sample_out_l, sample_out_r);
    end
    step();
    n_cmp++;
    if (sample_out_rdy !== 1'b0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_width: rdy=%b und=%b required 0/0 one cycle later", sample_out_rdy, underrun);
    end
    last_strobe = at;
  endtask

  task automatic test_burst_fill();
    int at;
    bit ok;
    logic signed [17:0] el;
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_l = 18'(i); s_r = -18'(i);
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_ready_%0d: s_ready=%b required 1", i, s_ready);
      end
      step();
    end
    s_valid = 1'b0;
    n_cmp++;
    if (s_ready !== 1'b0 || fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL burst_full: s_ready=%b lvl=%0d required 0/4", s_ready, fifo_level);
    end
    while (cyc < last_strobe + SP - 1) step();
    n_cmp++;
    if (s_ready !== 1'b0 || sample_out_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_tick_cycle: s_ready=%b rdy=%b required 0/0", s_ready, sample_out_rdy);
    end
    for (int k = 1; k <= 4; k++) begin
      wait_strobe(at, ok);
      el = 18'(k);
      n_cmp++;
      if (!ok || at - last_strobe !== SP) begin
        n_fail++;
        $display("FAIL burst_spacing_%0d: ok=%0b spacing %0d required %0d", k, ok, at - last_strobe, SP);
      end
      n_cmp++;
      if (sample_out_l !== el || sample_out_r !== -el || underrun !== 1'b0 ||
          fifo_level !== 3'(4 - k) || s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_data_%0d: l=%0d r=%0d und=%b lvl=%0d s_ready=%b required %0d/%0d/0/%0d/1",
                 k, sample_out_l, sample_out_r, underrun, fifo_level, s_ready, el, -el, 4 - k);
      end
      last_strobe = at;
    end
  endtask

  task automatic test_underrun();
    int at;
    bit ok;
    logic signed [17:0] el;
    el = HOLD ? 18'sd4 : 18'sd0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(at, ok);
      n_cmp++;
      if (!ok || at - last_strobe !== SP || underrun !== 1'b1 ||
          sample_out_l !== el || sample_out_r !== -el || fifo_level !== 3'd0) begin
        n_fail++;
        $display("FAIL underrun_%0d: ok=%0b spacing=%0d und=%b l=%0d r=%0d lvl=%0d required %0d/1/%0d/%0d/0",
                 k, ok, at - last_strobe, underrun, sample_out_l, sample_out_r, fifo_level, SP, el, -el);
      end
      last_strobe = at;
    end
  endtask

  task automatic test_tick_collision();
    int at;
    bit ok;
    logic signed [17:0] el;
    el = HOLD ? 18'sd4 : 18'sd0;
    while (cyc < last_strobe + SP - 1) step();
    s_valid = 1'b1; s_l = 18'sh1FFFF; s_r = 18'sh20000;
    step();
    s_valid = 1'b0;
    n_cmp++;
    if (sample_out_rdy !== 1'b1 || underrun !== 1'b1 || fifo_level !== 3'd1 ||
        sample_out_l !== el || sample_out_r !== -el) begin
      n_fail++;
      $display("FAIL collision_tick: rdy=%b und=%b lvl=%0d l=%0d r=%0d required 1/1/1/%0d/%0d",
               sample_out_rdy, underrun, fifo_level, sample_out_l, sample_out_r, el, -el);
    end
    last_strobe = cyc;
    wait_strobe(at, ok);
    n_cmp++;
    if (!ok || at - last_strobe !== SP || underrun !== 1'b0 ||
        sample_out_l !== 18'sh1FFFF || sample_out_r !== 18'sh20000) begin
      n_fail++;
      $display("FAIL collision_next: ok=%0b spacing=%0d und=%b l=%h r=%h required 1ffff/20000",
               ok, at - last_strobe, underrun, sample_out_l, sample_out_r);
    end
    last_strobe = at;
  endtask

  task automatic test_full_pop();
    int at;
    bit ok;
    logic [35:0] pushed[$];
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_l = 18'($urandom()); s_r = 18'($urandom());
      pushed.push_back({s_l, s_r});
      step();
    end
    s_l = 18'($urandom()); s_r = 18'($urandom());
    while (cyc < last_strobe + SP - 1) step();
    n_cmp++;
    if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_tick: lvl=%0d s_ready=%b required 4/0", fifo_level, s_ready);
    end
    step();
    n_cmp++;
    if (sample_out_rdy !== 1'b1 || {sample_out_l, sample_out_r} !== pushed[0] ||
        fifo_level !== 3'd3 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop: rdy=%b word=%h lvl=%0d s_ready=%b required 1/%h/3/1",
               sample_out_rdy, {sample_out_l, sample_out_r}, fifo_level, s_ready, pushed[0]);
    end
    last_strobe = cyc;
    step();
    s_valid = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_refill: lvl=%0d s_ready=%b required 4/0", fifo_level, s_ready);
    end
    wait_strobe(at, ok);
    n_cmp++;
    if (!ok || at - last_strobe !== SP || {sample_out_l, sample_out_r} !== pushed[1] || fifo_level !== 3'd3) begin
      n_fail++;
      $display("FAIL full_second: ok=%0b spacing=%0d word=%h lvl=%0d required %h/3",
               ok, at - last_strobe, {sample_out_l, sample_out_r}, fifo_level, pushed[1]);
    end
    last_strobe = at;
  endtask

  task automatic test_mid_reset();
    int at;
    bit ok;
    repeat (1000) step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (fifo_level !== 3'd0 || sample_out_l !== 18'sd0 || sample_out_r !== 18'sd0 ||
        sample_out_rdy !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: lvl=%0d l=%0d r=%0d rdy=%b s_ready=%b required 0/0/0/0/0",
               fifo_level, sample_out_l, sample_out_r, sample_out_rdy, s_ready);
    end
    reset = 1'b1;
    last_strobe = cyc;
    wait_strobe(at, ok);
    n_cmp++;
    if (!ok || at - last_strobe !== SP || underrun !== 1'b1 ||
        sample_out_l !== 18'sd0 || sample_out_r !== 18'sd0) begin
      n_fail++;
      $display("FAIL midreset_strobe: ok=%0b spacing=%0d und=%b l=%0d r=%0d required %0d/1/0/0",
               ok, at - last_strobe, underrun, sample_out_l, sample_out_r, SP);
    end
    last_strobe = at;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 6 * SP; i++) begin
      s_valid = (i < 3 * SP) ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3999) == 0);
      s_l = 18'($urandom()); s_r = 18'($urandom());
      step();
      n_cmp++;
      if (sample_out_rdy !== m_strobe || underrun !== m_und || sample_out_l !== m_l ||
          sample_out_r !== m_r || fifo_level !== 3'(m_q.size()) ||
          s_ready !== (m_q.size() < DEPTH)) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_cyc%0d: rdy=%b und=%b l=%h r=%h lvl=%0d s_ready=%b required %b/%b/%h/%h/%0d/%b",
                   cyc, sample_out_rdy, underrun, sample_out_l, sample_out_r, fifo_level, s_ready,
                   m_strobe, m_und, m_l, m_r, m_q.size(), m_q.size() < DEPTH);
        bad++;
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst_fill();
    test_underrun();
    test_tick_collision();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
